booth8_seq_mult: RTL and testbench
==================================

# booth8_seq_mult

Parametrised, iterative radix-8 Booth multiplier with a valid/ready handshake on both sides. It computes the exact 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned per transaction, retiring DPC recoded digits per clock. It is the area-lean sibling of the combinational Booth/Wallace multiplier and serves datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 32, operand width in bits; WIDTH ≥ 4.
- DPC, 1, Booth digits retired per RUN cycle; 1 ≤ DPC ≤ NDIG.
- Derived: E = 3·ceil((WIDTH+1)/3) is the extended multiplier width. NDIG = E/3. NCYC = ceil(NDIG/DPC). For WIDTH=32: E=33, NDIG=11, NCYC=11 at DPC=1.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation (high only in IDLE).
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- mcand  in  WIDTH  multiplicand.
- mplier  in  WIDTH  multiplier.
- out_valid  out  1  product is valid.
- out_ready  in  1  consumer accepts the product.
- product  out  2·WIDTH  exact product; held stable while out_valid=1.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. An accept (in_valid & in_ready) does the following:
  - Latch M = mcand extended to WIDTH+3 bits (sign-extended if in_signed, else zero-extended).
  - Latch 3M = M + 2M into a register (hard multiple).
  - Latch Q = mplier extended to E bits (sign or zero per in_signed), with an appended 0 below bit 0.
  - Clear the accumulator and the digit counter k. Go to RUN.
- Digit i = −4·Q[3i+2] + 2·Q[3i+1] + Q[3i] + Q[3i−1], where Q[−1]=0. Range −4..+4.
- Partial product per digit: 0, ±M, ±2M, ±3M, ±4M. Negation is two's complement at full accumulator width (2·WIDTH+3 bits, sign-extended).
- RUN: each cycle adds DPC partial products, digit i weighted by 2^(3i). Digits with i ≥ NDIG contribute 0. k increments by 1 per cycle. After the cycle with k = NCYC−1, go to DONE.
- Product = low 2·WIDTH bits of the accumulator. The result is exact for all inputs in both modes (no overflow or saturation).
- DONE: out_valid=1 and product is stable. On out_ready=1, go to IDLE at that edge. in_valid is ignored outside IDLE.
- in_signed is sampled only at accept. Toggling it mid-operation has no effect.
- Reset (any state, any time): state→IDLE, out_valid=0, product=0, accumulator/M/3M/Q/k=0. Any in-flight operation is discarded and no output is produced for it.

## Timing
- Reset values: in_ready=1, out_valid=0, product=0.
- Accept at edge T. RUN occupies edges T+1 … T+NCYC. out_valid rises after edge T+NCYC.
- Latency from accept to out_valid is NCYC cycles (11 at WIDTH=32, DPC=1; 1 at DPC=NDIG).
- Output handshake at edge U → out_valid=0 and in_ready=1 after U. The next accept is possible at edge U+1. There is no overlap between transactions.
- Throughput is at most one operation per NCYC+2 cycles with out_ready tied high.
- in_ready and out_valid are pure state decodes, with no combinational path from in_valid or out_ready.
- product is registered and changes only on the final RUN edge or on reset.

## Test plan
- WIDTH=32, DPC=1, in_signed=1: mcand=0xFFFFFFFF, mplier=0xFFFFFFFF → after 11 cycles out_valid=1, product=0x0000000000000001.
- Unsigned mode: 0xFFFFFFFF × 0xFFFFFFFF → product=0xFFFFFFFE00000001. Signed mode with the same inputs immediately after → 0x0000000000000001. This confirms in_signed is latched per transaction.
- Signed corner cases:
  - 0x80000000 × 0x80000000 → 0x4000000000000000.
  - 0x80000000 × 0x7FFFFFFF → 0xC000000080000000.
  - 0x00000003 × 0xFFFFFFFD → 0xFFFFFFFFFFFFFFF7.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. product stays constant, in_ready stays 0, and a pulsed in_valid with new operands is ignored. out_ready=1 → in_ready=1 next cycle, and the next op completes correctly.
- Reset mid-RUN: assert rst asynchronously at RUN cycle 4 (mid-cycle, not edge-aligned). out_valid=0, product=0, in_ready=1 immediately. After release, 7 × 6 → 42 with full 11-cycle latency.
- Parameter sweep: DPC ∈ {1, 3, 11} for WIDTH=32, and WIDTH ∈ {8, 17} for DPC=1. Use 10k random operands per mode against a reference model. Latency must equal NCYC exactly (WIDTH=8: NDIG=3; WIDTH=17: NDIG=6).

Source files
------------

// File: rtl/booth8_seq_mult_if.sv
// Handshake bundle for booth8_seq_mult: operand request channel and product response channel.
interface booth8_seq_mult_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, in_signed, mcand, mplier, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, in_signed, mcand, mplier, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth8_seq_mult.sv
// Iterative radix-8 Booth multiplier: retires DPC recoded digits per RUN cycle,
// signed or unsigned per transaction, with valid/ready on both sides.
module booth8_seq_mult #(
    parameter int WIDTH = 32,
    parameter int DPC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    booth8_seq_mult_if.slave  bus
);
    localparam int E    = 3 * ((WIDTH + 3) / 3);
    localparam int NDIG = E / 3;
    localparam int NCYC = (NDIG + DPC - 1) / DPC;
    localparam int AW   = 2 * WIDTH + 3;
    localparam int QW   = E + 1;
    localparam int KW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [AW-1:0]        m_q, m_d;
    logic [AW-1:0]        m3_q, m3_d;
    logic [QW-1:0]        q_q, q_d;
    logic [KW-1:0]        k_q, k_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [AW-1:0]        pp_sum;
    logic [AW-1:0]        m_ext;
    logic [E-1:0]         q_ext;
    logic                 last_cycle;

    assign last_cycle = (k_q == KW'(NCYC - 1));

    // Window {Q[3i+2], Q[3i+1], Q[3i], Q[3i-1]} selects a multiple in -4M..+4M.
    function automatic logic [AW-1:0] booth_pp(
        input logic [3:0]    win,
        input logic [AW-1:0] m,
        input logic [AW-1:0] m3
    );
        logic [AW-1:0] r;
        case (win)
            4'b0000, 4'b1111: r = '0;
            4'b0001, 4'b0010: r = m;
            4'b0011, 4'b0100: r = m << 1;
            4'b0101, 4'b0110: r = m3;
            4'b0111:          r = m << 2;
            4'b1000:          r = -(m << 2);
            4'b1001, 4'b1010: r = -m3;
            4'b1011, 4'b1100: r = -(m << 1);
            default:          r = -m;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last_cycle)   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes; product comes straight from its register.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.product   = product_q;
    end

    // Multiples are pre-shifted each cycle, so digit j of the current group sits at weight 2^(3j).
    always_comb begin
        pp_sum = '0;
        for (int j = 0; j < DPC; j++) begin
            if (int'(k_q) * DPC + j < NDIG) begin
                pp_sum = pp_sum + booth_pp(q_q[3*j +: 4], m_q << (3*j), m3_q << (3*j));
            end
        end
    end

    always_comb begin
        m_ext = {{(AW-WIDTH){bus.in_signed & bus.mcand[WIDTH-1]}}, bus.mcand};
        q_ext = {{(E-WIDTH){bus.in_signed & bus.mplier[WIDTH-1]}}, bus.mplier};
    end

    always_comb begin
        acc_d     = acc_q;
        m_d       = m_q;
        m3_d      = m3_q;
        q_d       = q_q;
        k_d       = k_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d   = m_ext;
                    m3_d  = m_ext + (m_ext << 1);
                    q_d   = {q_ext, 1'b0};
                    acc_d = '0;
                    k_d   = '0;
                end
            end
            RUN: begin
                acc_d = acc_q + pp_sum;
                m_d   = m_q << (3 * DPC);
                m3_d  = m3_q << (3 * DPC);
                q_d   = q_q >> (3 * DPC);
                k_d   = k_q + 1'b1;
                if (last_cycle) begin
                    product_d = acc_d[2*WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    // NOTE: every datapath register is reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            m_q       <= '0;
            m3_q      <= '0;
            q_q       <= '0;
            k_q       <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking here; all _d values were formed with blocking assigns above.
            acc_q     <= acc_d;
            m_q       <= m_d;
            m3_q      <= m3_d;
            q_q       <= q_d;
            k_q       <= k_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_booth8_seq_mult.sv
// Directed bench for booth8_seq_mult: five configurations driven in lockstep,
// latency and product checked per transaction against hand values and a reference product.
module tb_booth8_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    booth8_seq_mult_if #(.WIDTH(32)) if_d1 ();
    booth8_seq_mult_if #(.WIDTH(32)) if_d3 ();
    booth8_seq_mult_if #(.WIDTH(32)) if_d11 ();
    booth8_seq_mult_if #(.WIDTH(8))  if_w8 ();
    booth8_seq_mult_if #(.WIDTH(17)) if_w17 ();

    booth8_seq_mult #(.WIDTH(32), .DPC(1))  u_d1  (.clk(clk), .rst(rst), .bus(if_d1));
    booth8_seq_mult #(.WIDTH(32), .DPC(3))  u_d3  (.clk(clk), .rst(rst), .bus(if_d3));
    booth8_seq_mult #(.WIDTH(32), .DPC(11)) u_d11 (.clk(clk), .rst(rst), .bus(if_d11));
    booth8_seq_mult #(.WIDTH(8),  .DPC(1))  u_w8  (.clk(clk), .rst(rst), .bus(if_w8));
    booth8_seq_mult #(.WIDTH(17), .DPC(1))  u_w17 (.clk(clk), .rst(rst), .bus(if_w17));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        if_d1.in_valid  = v; if_d1.mcand  = a;       if_d1.mplier  = b;       if_d1.in_signed  = s;
        if_d3.in_valid  = v; if_d3.mcand  = a;       if_d3.mplier  = b;       if_d3.in_signed  = s;
        if_d11.in_valid = v; if_d11.mcand = a;       if_d11.mplier = b;       if_d11.in_signed = s;
        if_w8.in_valid  = v; if_w8.mcand  = a[7:0];  if_w8.mplier  = b[7:0];  if_w8.in_signed  = s;
        if_w17.in_valid = v; if_w17.mcand = a[16:0]; if_w17.mplier = b[16:0]; if_w17.in_signed = s;
    endtask

    task automatic set_ordy(input logic r);
        if_d1.out_ready  = r;
        if_d3.out_ready  = r;
        if_d11.out_ready = r;
        if_w8.out_ready  = r;
        if_w17.out_ready = r;
    endtask

    function automatic logic get_ov(input int i);
        case (i)
            0:       return if_d1.out_valid;
            1:       return if_d3.out_valid;
            2:       return if_d11.out_valid;
            3:       return if_w8.out_valid;
            default: return if_w17.out_valid;
        endcase
    endfunction

    function automatic logic [63:0] get_prod(input int i);
        case (i)
            0:       return if_d1.product;
            1:       return if_d3.product;
            2:       return if_d11.product;
            3:       return {48'b0, if_w8.product};
            default: return {30'b0, if_w17.product};
        endcase
    endfunction

    // Reference product for a w-bit operand pair, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input int w);
        logic [63:0] mask, x, y, p;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x = {32'b0, a} & mask;
        y = {32'b0, b} & mask;
        if (s && x[w-1]) x = x | ~mask;
        if (s && y[w-1]) y = y | ~mask;
        p = x * y;
        if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
        return p;
    endfunction

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int hold, input logic [63:0] exp_main);
        int ncyc [5] = '{11, 4, 1, 3, 6};
        int wid  [5] = '{32, 32, 32, 8, 17};
        int lat  [5] = '{-1, -1, -1, -1, -1};
        drive(1'b1, a, b, s);
        @(posedge clk); #1;
        // Mode and operands flip right after accept; the DUT must ignore them.
        drive(1'b0, ~a, ~b, ~s);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++) begin
                if (get_ov(i) && lat[i] < 0) lat[i] = c;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s lat%0d", tag, i), 64'(lat[i]), 64'(ncyc[i]));
            check($sformatf("%s prod%0d", tag, i), get_prod(i), ref_mul(a, b, s, wid[i]));
        end
        check({tag, " main"}, get_prod(0), exp_main);
        for (int h = 1; h <= hold; h++) begin
            if (h == 2) drive(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
            @(posedge clk); #1;
            if (h == 2) drive(1'b0, 32'h0, 32'h0, 1'b0);
            check($sformatf("%s hold%0d prod", tag, h), get_prod(0), exp_main);
            check($sformatf("%s hold%0d in_ready", tag, h), 64'(if_d1.in_ready), 64'd0);
            check($sformatf("%s hold%0d out_valid", tag, h), 64'(if_d1.out_valid), 64'd1);
        end
        set_ordy(1'b1);
        @(posedge clk); #1;
        set_ordy(1'b0);
        check({tag, " post in_ready"}, 64'(if_d1.in_ready), 64'd1);
        check({tag, " post out_valid"}, 64'(if_d1.out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        set_ordy(1'b0);
        #23;
        check("reset in_ready", 64'(if_d1.in_ready), 64'd1);
        check("reset out_valid", 64'(if_d1.out_valid), 64'd0);
        check("reset product", get_prod(0), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("s_ff_ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 64'h0000_0000_0000_0001);
        do_op("u_ff_ff",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 64'hFFFF_FFFE_0000_0001);
        do_op("s_ff_ff2",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 64'h0000_0000_0000_0001);
        do_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 64'h4000_0000_0000_0000);
        do_op("s_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 64'hC000_0000_8000_0000);
        do_op("s_3_m3",    32'h0000_0003, 32'hFFFF_FFFD, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFF7);
        do_op("bp",        32'h0001_2345, 32'h0000_0100, 1'b1, 5, 64'h0000_0000_0123_4500);
        do_op("after_bp",  32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0, 64'h0000_0000_FFFE_0001);

        // Abort mid-RUN with an asynchronous, non-edge-aligned reset.
        drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst in_ready", 64'(if_d1.in_ready), 64'd1);
        check("mid_rst out_valid", 64'(if_d1.out_valid), 64'd0);
        check("mid_rst product", get_prod(0), 64'd0);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("rst_7x6", 32'd7, 32'd6, 1'b1, 0, 64'd42);

        for (int n = 0; n < 100; n++) begin
            for (int s = 0; s < 2; s++) begin
                ra = $urandom;
                rb = $urandom;
                do_op($sformatf("rnd%0d_s%0d", n, s), ra, rb, s[0], 0, ref_mul(ra, rb, s[0], 32));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
